// File: rtl/y_huff.sv
// y_huff: baseline JPEG luminance Huffman coder for one 8x8 block.
// Walks the captured block in zigzag order, emits DC-differential and AC
// run/size codes with amplitude bits, and packs them MSB-first into 32-bit words.
module y_huff (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [10:0] Y11, Y12, Y13, Y14, Y15, Y16, Y17, Y18,
    input  logic [10:0] Y21, Y22, Y23, Y24, Y25, Y26, Y27, Y28,
    input  logic [10:0] Y31, Y32, Y33, Y34, Y35, Y36, Y37, Y38,
    input  logic [10:0] Y41, Y42, Y43, Y44, Y45, Y46, Y47, Y48,
    input  logic [10:0] Y51, Y52, Y53, Y54, Y55, Y56, Y57, Y58,
    input  logic [10:0] Y61, Y62, Y63, Y64, Y65, Y66, Y67, Y68,
    input  logic [10:0] Y71, Y72, Y73, Y74, Y75, Y76, Y77, Y78,
    input  logic [10:0] Y81, Y82, Y83, Y84, Y85, Y86, Y87, Y88,
    output logic [31:0] JPEG_bitstream,
    output logic        data_ready,
    output logic [4:0]  output_reg_count,
    output logic        end_of_block_output,
    output logic        end_of_block_empty
);

    typedef enum logic [1:0] {IDLE, ENCODE, FLUSH} state_t;

    // Luminance AC table in BITS/HUFFVAL form; codes are built canonically.
    localparam logic [127:0] AC_BITS = {
        8'd0, 8'd2, 8'd1, 8'd3, 8'd3, 8'd2, 8'd4, 8'd3,
        8'd5, 8'd5, 8'd4, 8'd4, 8'd0, 8'd0, 8'd1, 8'd125};

    localparam logic [1295:0] AC_VALS = {
        64'h0102030004110512, 64'h2131410613516107, 64'h2271143281_91a108,
        64'h2342b1c11552d1f0, 64'h243362728209_0a16, 64'h1718191a25262728,
        64'h292a343536373839, 64'h3a43444546474849, 64'h4a53545556575859,
        64'h5a63646566676869, 64'h6a73747576777879, 64'h7a83848586878889,
        64'h8a92939495969798, 64'h999aa2a3a4a5a6a7, 64'ha8a9aab2b3b4b5b6,
        64'hb7b8b9bac2c3c4c5, 64'hc6c7c8c9cad2d3d4, 64'hd5d6d7d8d9dae1e2,
        64'he3e4e5e6e7e8e9ea, 64'hf1f2f3f4f5f6f7f8, 16'hf9fa};

    // Returns {length[4:0], code[15:0]} for run/size byte rs; length 0 if unused.
    function automatic logic [20:0] ac_lookup(input int unsigned rs);
        int unsigned code;
        int unsigned idx;
        logic [7:0]  cnt;
        logic [7:0]  val;
        ac_lookup = '0;
        code = 0;
        idx  = 0;
        for (int unsigned len = 1; len <= 16; len++) begin
            cnt = AC_BITS[(16 - len) * 8 +: 8];
            for (int unsigned k = 0; k < 32'(cnt); k++) begin
                val = AC_VALS[(161 - idx) * 8 +: 8];
                if (32'(val) == rs)
                    ac_lookup = {len[4:0], code[15:0]};
                code++;
                idx++;
            end
            code = code << 1;
        end
    endfunction

    // Luminance DC table: {length[4:0], code[15:0]} per category.
    function automatic logic [20:0] dc_lookup(input logic [3:0] cat);
        case (cat)
            4'd0:    dc_lookup = {5'd2, 16'h0000};
            4'd1:    dc_lookup = {5'd3, 16'h0002};
            4'd2:    dc_lookup = {5'd3, 16'h0003};
            4'd3:    dc_lookup = {5'd3, 16'h0004};
            4'd4:    dc_lookup = {5'd3, 16'h0005};
            4'd5:    dc_lookup = {5'd3, 16'h0006};
            4'd6:    dc_lookup = {5'd4, 16'h000E};
            4'd7:    dc_lookup = {5'd5, 16'h001E};
            4'd8:    dc_lookup = {5'd6, 16'h003E};
            4'd9:    dc_lookup = {5'd7, 16'h007E};
            4'd10:   dc_lookup = {5'd8, 16'h00FE};
            default: dc_lookup = {5'd9, 16'h01FE};
        endcase
    endfunction

    function automatic logic [3:0] bit_len(input logic [11:0] m);
        bit_len = '0;
        for (int unsigned b = 0; b < 12; b++)
            if (m[b]) bit_len = 4'(b + 1);
    endfunction

    logic [20:0] ac_rom [256];

    for (genvar g = 0; g < 256; g++) begin : g_ac_rom
        localparam logic [20:0] ENTRY = ac_lookup(g);
        assign ac_rom[g] = ENTRY;
    end

    state_t      state;
    logic [5:0]  idx;
    logic [5:0]  run;
    logic [10:0] coef_sr [64];
    logic [63:0] nz_sr;
    logic [10:0] prev_dc;
    logic [57:0] acc;
    logic [4:0]  acc_cnt;

    logic [10:0] zz [64];
    logic [63:0] zz_nz;

    // Zigzag reordering of the block inputs plus a nonzero flag per position.
    always_comb begin
        zz[0]  = Y11; zz[1]  = Y12; zz[2]  = Y21; zz[3]  = Y31; zz[4]  = Y22; zz[5]  = Y13; zz[6]  = Y14; zz[7]  = Y23;
        zz[8]  = Y32; zz[9]  = Y41; zz[10] = Y51; zz[11] = Y42; zz[12] = Y33; zz[13] = Y24; zz[14] = Y15; zz[15] = Y16;
        zz[16] = Y25; zz[17] = Y34; zz[18] = Y43; zz[19] = Y52; zz[20] = Y61; zz[21] = Y71; zz[22] = Y62; zz[23] = Y53;
        zz[24] = Y44; zz[25] = Y35; zz[26] = Y26; zz[27] = Y17; zz[28] = Y18; zz[29] = Y27; zz[30] = Y36; zz[31] = Y45;
        zz[32] = Y54; zz[33] = Y63; zz[34] = Y72; zz[35] = Y81; zz[36] = Y82; zz[37] = Y73; zz[38] = Y64; zz[39] = Y55;
        zz[40] = Y46; zz[41] = Y37; zz[42] = Y28; zz[43] = Y38; zz[44] = Y47; zz[45] = Y56; zz[46] = Y65; zz[47] = Y74;
        zz[48] = Y83; zz[49] = Y84; zz[50] = Y75; zz[51] = Y66; zz[52] = Y57; zz[53] = Y48; zz[54] = Y58; zz[55] = Y67;
        zz[56] = Y76; zz[57] = Y85; zz[58] = Y86; zz[59] = Y77; zz[60] = Y68; zz[61] = Y78; zz[62] = Y87; zz[63] = Y88;
        for (int unsigned k = 0; k < 64; k++)
            zz_nz[k] = |zz[k];
    end

    logic [10:0] cur;
    logic [11:0] dc_diff, val, mag, amp_raw, amp_full;
    logic [3:0]  cat;
    logic        tail_nz;
    logic [20:0] huff;
    logic [15:0] ins_code;
    logic [4:0]  ins_clen;
    logic [11:0] ins_amp;
    logic [3:0]  ins_alen;
    logic [5:0]  run_next;
    logic [4:0]  nbits;
    logic [26:0] rj, lj;
    logic [57:0] combined;
    logic [5:0]  total;

    // Symbol selection for the current zigzag position and bit packing.
    // ZRLs are emitted as soon as 16 zeros accumulate, but only when the
    // captured nonzero mask shows a later nonzero coefficient; the bit stream
    // is identical to deferring them, and no cycle ever appends more than 26 bits.
    always_comb begin
        cur      = coef_sr[0];
        dc_diff  = {cur[10], cur} - {prev_dc[10], prev_dc};
        val      = (idx == 6'd0) ? dc_diff : {cur[10], cur};
        mag      = val[11] ? (12'd0 - val) : val;
        cat      = bit_len(mag);
        amp_raw  = val[11] ? (val - 12'd1) : val;
        amp_full = amp_raw & ((12'd1 << cat) - 12'd1);
        tail_nz  = |nz_sr[63:1];
        huff     = '0;
        ins_amp  = '0;
        ins_alen = '0;
        run_next = run;
        if (state == ENCODE) begin
            if (idx == 6'd0) begin
                huff     = dc_lookup(cat);
                ins_amp  = amp_full;
                ins_alen = cat;
            end else if (nz_sr[0]) begin
                huff     = ac_rom[{run[3:0], cat}];
                ins_amp  = amp_full;
                ins_alen = cat;
                run_next = '0;
            end else if (idx == 6'd63) begin
                huff     = ac_rom[8'h00];
                run_next = '0;
            end else if (run == 6'd15 && tail_nz) begin
                huff     = ac_rom[8'hF0];
                run_next = '0;
            end else begin
                run_next = run + 6'd1;
            end
        end
        ins_clen = huff[20:16];
        ins_code = huff[15:0];
        nbits    = ins_clen + {1'b0, ins_alen};
        rj       = ({11'b0, ins_code} << ins_alen) | {15'b0, ins_amp};
        lj       = rj << (5'd27 - nbits);
        combined = acc | ({lj, 31'b0} >> acc_cnt);
        total    = {1'b0, acc_cnt} + {1'b0, nbits};
    end

    // Control FSM, coefficient shift register, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            idx                 <= '0;
            run                 <= '0;
            for (int unsigned k = 0; k < 64; k++) coef_sr[k] <= '0;
            nz_sr               <= '0;
            prev_dc             <= '0;
            acc                 <= '0;
            acc_cnt             <= '0;
            JPEG_bitstream      <= '0;
            data_ready          <= 1'b0;
            output_reg_count    <= '0;
            end_of_block_output <= 1'b0;
            end_of_block_empty  <= 1'b0;
        end else begin
            data_ready          <= 1'b0;
            end_of_block_output <= 1'b0;
            end_of_block_empty  <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        for (int unsigned k = 0; k < 64; k++) coef_sr[k] <= zz[k];
                        nz_sr <= zz_nz;
                        idx   <= '0;
                        run   <= '0;
                        state <= ENCODE;
                    end
                end
                ENCODE: begin
                    for (int unsigned k = 0; k < 63; k++) coef_sr[k] <= coef_sr[k + 1];
                    coef_sr[63] <= '0;
                    nz_sr <= nz_sr >> 1;
                    run   <= run_next;
                    idx   <= idx + 6'd1;
                    if (idx == 6'd0) prev_dc <= cur;
                    // total < 58 always, so the remainder after a word is total[4:0].
                    if (total[5]) begin
                        JPEG_bitstream <= combined[57:26];
                        data_ready     <= 1'b1;
                        acc            <= combined << 32;
                    end else begin
                        acc <= combined;
                    end
                    acc_cnt <= total[4:0];
                    if (idx == 6'd63) state <= FLUSH;
                end
                FLUSH: begin
                    JPEG_bitstream      <= acc[57:26];
                    output_reg_count    <= acc_cnt;
                    end_of_block_output <= 1'b1;
                    end_of_block_empty  <= (acc_cnt == 5'd0);
                    acc                 <= '0;
                    acc_cnt             <= '0;
                    state               <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_y_huff.sv
// Scoreboard bench for y_huff: directed blocks with hand-derived bit streams.
module tb_y_huff;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [10:0] y [1:8][1:8];
    logic [31:0] JPEG_bitstream;
    logic        data_ready;
    logic [4:0]  output_reg_count;
    logic        end_of_block_output;
    logic        end_of_block_empty;

    typedef struct {
        bit          is_eob;
        logic [31:0] data;
        logic [4:0]  cnt;
        bit          empty;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    y_huff dut (
        .clk(clk), .rst(rst), .enable(enable),
        .Y11(y[1][1]), .Y12(y[1][2]), .Y13(y[1][3]), .Y14(y[1][4]), .Y15(y[1][5]), .Y16(y[1][6]), .Y17(y[1][7]), .Y18(y[1][8]),
        .Y21(y[2][1]), .Y22(y[2][2]), .Y23(y[2][3]), .Y24(y[2][4]), .Y25(y[2][5]), .Y26(y[2][6]), .Y27(y[2][7]), .Y28(y[2][8]),
        .Y31(y[3][1]), .Y32(y[3][2]), .Y33(y[3][3]), .Y34(y[3][4]), .Y35(y[3][5]), .Y36(y[3][6]), .Y37(y[3][7]), .Y38(y[3][8]),
        .Y41(y[4][1]), .Y42(y[4][2]), .Y43(y[4][3]), .Y44(y[4][4]), .Y45(y[4][5]), .Y46(y[4][6]), .Y47(y[4][7]), .Y48(y[4][8]),
        .Y51(y[5][1]), .Y52(y[5][2]), .Y53(y[5][3]), .Y54(y[5][4]), .Y55(y[5][5]), .Y56(y[5][6]), .Y57(y[5][7]), .Y58(y[5][8]),
        .Y61(y[6][1]), .Y62(y[6][2]), .Y63(y[6][3]), .Y64(y[6][4]), .Y65(y[6][5]), .Y66(y[6][6]), .Y67(y[6][7]), .Y68(y[6][8]),
        .Y71(y[7][1]), .Y72(y[7][2]), .Y73(y[7][3]), .Y74(y[7][4]), .Y75(y[7][5]), .Y76(y[7][6]), .Y77(y[7][7]), .Y78(y[7][8]),
        .Y81(y[8][1]), .Y82(y[8][2]), .Y83(y[8][3]), .Y84(y[8][4]), .Y85(y[8][5]), .Y86(y[8][6]), .Y87(y[8][7]), .Y88(y[8][8]),
        .JPEG_bitstream(JPEG_bitstream), .data_ready(data_ready),
        .output_reg_count(output_reg_count),
        .end_of_block_output(end_of_block_output),
        .end_of_block_empty(end_of_block_empty)
    );

    task automatic clear_block();
        for (int r = 1; r <= 8; r++)
            for (int c = 1; c <= 8; c++)
                y[r][c] = '0;
    endtask

    task automatic expect_word(input logic [31:0] d);
        exp_t e;
        e.is_eob = 1'b0; e.data = d; e.cnt = '0; e.empty = 1'b0;
        sb.push_back(e);
    endtask

    task automatic expect_eob(input logic [31:0] d, input logic [4:0] c);
        exp_t e;
        e.is_eob = 1'b1; e.data = d; e.cnt = c; e.empty = (c == 5'd0);
        sb.push_back(e);
    endtask

    task automatic pulse_enable();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Starts a block and waits (bounded) for every queued expectation to be consumed.
    task automatic run_block(input string name, input int extra_pulse_after);
        pulse_enable();
        if (extra_pulse_after > 0) begin
            repeat (extra_pulse_after) @(negedge clk);
            pulse_enable();
        end
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d outputs still pending, required 0", name, sb.size());
            sb.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    // Pops one expectation whenever the DUT presents a word or end-of-block.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && (data_ready || end_of_block_output)) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got ready=%0b eob=%0b word=%h, required no output",
                             data_ready, end_of_block_output, JPEG_bitstream);
                end else begin
                    e = sb.pop_front();
                    if (data_ready == e.is_eob || end_of_block_output != e.is_eob ||
                        JPEG_bitstream != e.data ||
                        (e.is_eob && (output_reg_count != e.cnt || end_of_block_empty != e.empty))) begin
                        errors++;
                        $display("FAIL %s: got ready=%0b eob=%0b word=%h cnt=%0d empty=%0b, required eob=%0b word=%h cnt=%0d empty=%0b",
                                 e.is_eob ? "eob" : "word", data_ready, end_of_block_output, JPEG_bitstream,
                                 output_reg_count, end_of_block_empty, e.is_eob, e.data, e.cnt, e.empty);
                    end
                end
            end
        end
    endtask

    initial begin
        rst    = 1'b0;
        enable = 1'b0;
        clear_block();
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        checks++;
        if ({JPEG_bitstream, data_ready, output_reg_count, end_of_block_output, end_of_block_empty} != '0) begin
            errors++;
            $display("FAIL reset_state: got word=%h ready=%0b cnt=%0d eob=%0b empty=%0b, required all 0",
                     JPEG_bitstream, data_ready, output_reg_count, end_of_block_output, end_of_block_empty);
        end
        rst = 1'b1;
        @(negedge clk);

        // DC 50, run1/size2, run2/size2, EOB: 31 bits
        clear_block();
        y[1][1] = 11'd50; y[2][1] = 11'd3; y[1][3] = 11'd2;
        expect_eob(32'hECB7FCD4, 5'd31);
        run_block("block1", 0);

        // 36 bits: one full word plus EOB left over
        do_reset();
        clear_block();
        y[1][1] = 11'd100; y[2][1] = 11'd5; y[1][3] = 11'd2;
        expect_word(32'hF64F37E6);
        expect_eob(32'hA0000000, 5'd4);
        run_block("block2", 0);

        // Same block twice: second DC diff is 0
        do_reset();
        clear_block();
        y[1][1] = 11'd50; y[2][1] = 11'd3; y[1][3] = 11'd2;
        expect_eob(32'hECB7FCD4, 5'd31);
        run_block("repeat_a", 0);
        expect_eob(32'h37FCD400, 5'd23);
        run_block("repeat_b", 0);

        // Negative DC, then an all-zero block
        do_reset();
        clear_block();
        y[1][1] = 11'h7FF;
        expect_eob(32'h4A000000, 5'd8);
        run_block("dc_neg1", 0);
        do_reset();
        clear_block();
        expect_eob(32'h28000000, 5'd6);
        run_block("all_zero", 0);

        // Only Y88 nonzero: 3 ZRLs + 14/1 code, no EOB; second enable mid-block ignored
        clear_block();
        y[8][8] = 11'd1;
        expect_word(32'h3FCFF9FF);
        expect_eob(32'h3FFD7000, 5'd20);
        run_block("y88_zrl", 10);

        // Abort mid-block: outputs clear at once, no end-of-block, predictor back to 0
        clear_block();
        y[1][1] = 11'd100;
        pulse_enable();
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({JPEG_bitstream, data_ready, output_reg_count, end_of_block_output, end_of_block_empty} != '0) begin
            errors++;
            $display("FAIL abort_reset: got word=%h ready=%0b cnt=%0d eob=%0b empty=%0b, required all 0",
                     JPEG_bitstream, data_ready, output_reg_count, end_of_block_output, end_of_block_empty);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        clear_block();
        y[1][1] = 11'd50; y[2][1] = 11'd3; y[1][3] = 11'd2;
        expect_eob(32'hECB7FCD4, 5'd31);
        run_block("after_abort", 0);

        // Exactly 32 bits (prevDC = 50, 26-bit 0/10 symbol): empty final word
        clear_block();
        y[1][1] = 11'd50; y[1][2] = 11'd512;
        expect_word(32'h3FE0E00A);
        expect_eob(32'h00000000, 5'd0);
        run_block("exact_word", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
